// File: rtl/butterfly_pkg.sv
// Shared definitions for the pipelined modular butterfly.
//   mode_e      : operating mode carried with every beat
//   DEF_*       : default modulus / widths (Dilithium prime, 23-bit lanes)
//   STAGES      : register stages between input accept and output
//   barrett_mu  : floor(2^(2*width) / q), elaboration-time constant
//   mod_add/sub : canonical modular add/sub of operands already in [0, q)
package butterfly_pkg;

    typedef enum logic [1:0] {
        MODE_CT     = 2'b00,
        MODE_GS     = 2'b01,
        MODE_ADDSUB = 2'b10
    } mode_e;

    localparam int          DEF_WIDTH = 23;
    localparam int unsigned DEF_Q     = 32'd8380417;
    localparam int          DEF_TAG_W = 8;
    localparam int          STAGES    = 4;

    function automatic logic [127:0] barrett_mu(input logic [63:0] q, input int width);
        return (128'd1 << (2 * width)) / {64'd0, q};
    endfunction

    // Operands < q, so the sum needs only one extra bit and one correction.
    function automatic logic [63:0] mod_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] q);
        logic [63:0] s;
        s = a + b;
        return (s >= q) ? s - q : s;
    endfunction

    function automatic logic [63:0] mod_sub(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] q);
        return (a >= b) ? a - b : a + q - b;
    endfunction

endpackage

// File: rtl/mod_reduce.sv
// Combinational Barrett reduction of a 2*WIDTH-bit product into [0, Q).
//   i_x : product, assumed < Q^2
//   o_r : i_x mod Q, canonical
// qhat = floor(x*mu / 2^(2K)) underestimates floor(x/Q) by at most 2, so the
// remainder lies in [0, 3Q) and two conditional subtracts make it exact.
module mod_reduce
    import butterfly_pkg::*;
#(
    parameter int          WIDTH = DEF_WIDTH,
    parameter int unsigned Q     = DEF_Q
) (
    input  logic [2*WIDTH-1:0] i_x,
    output logic [WIDTH-1:0]   o_r
);
    localparam int W2 = 2 * WIDTH;
    localparam int W4 = 4 * WIDTH;
    localparam int WR = WIDTH + 2;   // holds values up to 3Q

    localparam logic [W2-1:0] MU = W2'(barrett_mu(64'(Q), WIDTH));
    localparam logic [W2-1:0] Q2 = W2'(Q);
    localparam logic [WR-1:0] QR = WR'(Q);

    logic [W4-1:0] w_prod;
    logic [W2-1:0] w_qhat;
    logic [WR-1:0] w_r0;
    logic [WR-1:0] w_r1;
    logic [WR-1:0] w_r2;

    assign w_prod = W4'(i_x) * W4'(MU);
    assign w_qhat = W2'(w_prod >> W2);
    // True remainder < 2^WR, so computing modulo 2^WR is exact.
    assign w_r0   = WR'(i_x) - WR'(w_qhat * Q2);
    assign w_r1   = (w_r0 >= QR) ? w_r0 - QR : w_r0;
    assign w_r2   = (w_r1 >= QR) ? w_r1 - QR : w_r1;
    assign o_r    = WIDTH'(w_r2);

endmodule

// File: rtl/butterfly_pipe.sv
// Four-stage pipelined modular butterfly (CT / GS / ADDSUB) with a
// valid/ready handshake and an opaque tag that travels with each beat.
//   clk_i, rst_i               : clock, synchronous active-high reset
//   in_valid_i / in_ready_o    : input handshake (in_ready_o is combinational)
//   a_i, b_i, twiddle_i        : operands in [0, Q)
//   mode_i                     : 00 CT, 01 GS, 1x ADDSUB
//   tag_i / tag_o              : sideband returned with the result
//   out_valid_o / out_ready_i  : output handshake
//   a_out_o, b_out_o           : results
// Stages: S1 pre-add/sub + multiplier operand select, S2 raw product,
// S3 reduced product, S4 CT post add/sub into the output registers.
// A single global enable stalls the whole pipe; bubbles are kept.
module butterfly_pipe
    import butterfly_pkg::*;
#(
    parameter int          WIDTH = DEF_WIDTH,
    parameter int unsigned Q     = DEF_Q,
    parameter int          TAG_W = DEF_TAG_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] twiddle_i,
    input  logic [1:0]       mode_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] a_out_o,
    output logic [WIDTH-1:0] b_out_o,
    output logic [TAG_W-1:0] tag_o
);
    localparam int          W2 = 2 * WIDTH;
    localparam logic [63:0] QL = 64'(Q);

    logic              w_en;
    logic [STAGES:1]   r_vld_pipe;

    mode_e             w_mode;
    logic [WIDTH-1:0]  w_s1_x;
    logic [WIDTH-1:0]  w_s1_mop;
    logic [WIDTH-1:0]  w_s1_w;

    logic [WIDTH-1:0]  r1_x, r1_mop, r1_w;
    mode_e             r1_mode;
    logic [TAG_W-1:0]  r1_tag;

    logic [WIDTH-1:0]  r2_x;
    logic [W2-1:0]     r2_prod;
    mode_e             r2_mode;
    logic [TAG_W-1:0]  r2_tag;

    logic [WIDTH-1:0]  w_red;
    logic [WIDTH-1:0]  r3_x, r3_red;
    mode_e             r3_mode;
    logic [TAG_W-1:0]  r3_tag;

    logic [WIDTH-1:0]  w_s4_a, w_s4_b;
    logic [WIDTH-1:0]  r_a_out, r_b_out;
    logic [TAG_W-1:0]  r_tag_out;

    assign w_en        = ~r_vld_pipe[STAGES] | out_ready_i;
    assign in_ready_o  = w_en;
    assign out_valid_o = r_vld_pipe[STAGES];
    assign a_out_o     = r_a_out;
    assign b_out_o     = r_b_out;
    assign tag_o       = r_tag_out;

    // Reserved encoding folds into ADDSUB here so later stages see 3 modes.
    always_comb begin
        if (mode_i == 2'b00)      w_mode = MODE_CT;
        else if (mode_i == 2'b01) w_mode = MODE_GS;
        else                      w_mode = MODE_ADDSUB;
    end

    // CT multiplies b*w and finishes in S4. GS/ADDSUB do the add/sub here and
    // push (a-b) through the multiplier; ADDSUB uses w=1 so the product is
    // (a-b) itself and the reducer returns it unchanged.
    always_comb begin
        w_s1_x   = a_i;
        w_s1_mop = b_i;
        w_s1_w   = twiddle_i;
        if (w_mode != MODE_CT) begin
            w_s1_x   = WIDTH'(mod_add(64'(a_i), 64'(b_i), QL));
            w_s1_mop = WIDTH'(mod_sub(64'(a_i), 64'(b_i), QL));
            if (w_mode == MODE_ADDSUB) w_s1_w = WIDTH'(1);
        end
    end

    mod_reduce #(
        .WIDTH (WIDTH),
        .Q     (Q)
    ) u_reduce (
        .i_x (r2_prod),
        .o_r (w_red)
    );

    always_comb begin
        w_s4_a = r3_x;
        w_s4_b = r3_red;
        if (r3_mode == MODE_CT) begin
            w_s4_a = WIDTH'(mod_add(64'(r3_x), 64'(r3_red), QL));
            w_s4_b = WIDTH'(mod_sub(64'(r3_x), 64'(r3_red), QL));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld_pipe <= '0;
        end else if (w_en) begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid_i};
        end
    end

    // Internal data needs no reset: it is qualified by r_vld_pipe.
    always_ff @(posedge clk_i) begin
        if (w_en) begin
            r1_x    <= w_s1_x;
            r1_mop  <= w_s1_mop;
            r1_w    <= w_s1_w;
            r1_mode <= w_mode;
            r1_tag  <= tag_i;

            r2_x    <= r1_x;
            r2_prod <= W2'(r1_mop) * W2'(r1_w);
            r2_mode <= r1_mode;
            r2_tag  <= r1_tag;

            r3_x    <= r2_x;
            r3_red  <= w_red;
            r3_mode <= r2_mode;
            r3_tag  <= r2_tag;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a_out   <= '0;
            r_b_out   <= '0;
            r_tag_out <= '0;
        end else if (w_en) begin
            r_a_out   <= w_s4_a;
            r_b_out   <= w_s4_b;
            r_tag_out <= r3_tag;
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboard bench for butterfly_pipe: expected results are computed with
// plain % arithmetic when a beat is accepted and compared on output.
module tb_butterfly_pipe;
    localparam int              W  = 23;
    localparam int              TW = 8;
    localparam longint unsigned QV = 64'd8380417;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
        int            cyc;
        bit            lat;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [W-1:0]  a_i, b_i, twiddle_i;
    logic [1:0]    mode_i;
    logic [TW-1:0] tag_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [W-1:0]  a_out_o, b_out_o;
    logic [TW-1:0] tag_o;

    exp_t          sb[$];
    int            n_chk = 0;
    int            n_err = 0;
    int            cyc   = 0;
    logic [W-1:0]  drv_ea, drv_eb;
    bit            drv_lat;
    bit            prev_stall = 1'b0;
    logic [W-1:0]  prev_a, prev_b;
    logic [TW-1:0] prev_tag;

    butterfly_pipe #(.WIDTH(W), .Q(32'd8380417), .TAG_W(TW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .twiddle_i   (twiddle_i),
        .mode_i      (mode_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .a_out_o     (a_out_o),
        .b_out_o     (b_out_o),
        .tag_o       (tag_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic void model(input longint unsigned a, input longint unsigned b,
                                  input longint unsigned w, input logic [1:0] m,
                                  output longint unsigned ea, output longint unsigned eb);
        longint unsigned wb;
        case (m)
            2'b00: begin
                wb = (w * b) % QV;
                ea = (a + wb) % QV;
                eb = (a + QV - wb) % QV;
            end
            2'b01: begin
                ea = (a + b) % QV;
                eb = (((a + QV - b) % QV) * w) % QV;
            end
            default: begin
                ea = (a + b) % QV;
                eb = (a + QV - b) % QV;
            end
        endcase
    endfunction

    // Monitor: sample half a cycle after each active edge.
    always @(negedge clk_i) begin
        if (rst_i) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_vld", 64'(out_valid_o), 1);
                chk("hold_a", 64'(a_out_o), 64'(prev_a));
                chk("hold_b", 64'(b_out_o), 64'(prev_b));
                chk("hold_tag", 64'(tag_o), 64'(prev_tag));
            end
            if (out_valid_o && !out_ready_i) chk("stall_rdy", 64'(in_ready_o), 0);
            if (in_valid_i && in_ready_o)
                sb.push_back('{a: drv_ea, b: drv_eb, tag: tag_i, cyc: cyc, lat: drv_lat});
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 64'(sb.size() != 0), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("a_out", 64'(a_out_o), 64'(e.a));
                    chk("b_out", 64'(b_out_o), 64'(e.b));
                    chk("tag", 64'(tag_o), 64'(e.tag));
                    if (e.lat) chk("latency", 64'(cyc - e.cyc), 4);
                end
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_a     = a_out_o;
            prev_b     = b_out_o;
            prev_tag   = tag_o;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] w,
                        input logic [1:0] m, input logic [TW-1:0] t,
                        input longint unsigned ea, input longint unsigned eb);
        int k = 0;
        @(posedge clk_i); #1;
        a_i = a; b_i = b; twiddle_i = w; mode_i = m; tag_i = t;
        drv_ea = W'(ea); drv_eb = W'(eb);
        in_valid_i = 1'b1;
        @(negedge clk_i);
        while (!in_ready_o && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        if (k >= 100) chk("send_timeout", 64'(k), 0);
    endtask

    task automatic send_m(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] w,
                          input logic [1:0] m, input logic [TW-1:0] t);
        longint unsigned ea, eb;
        model(64'(a), 64'(b), 64'(w), m, ea, eb);
        send(a, b, w, m, t, ea, eb);
    endtask

    task automatic drain(input int max);
        int k = 0;
        @(posedge clk_i); #1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        do begin
            @(negedge clk_i);
            k++;
        end while (sb.size() != 0 && k < max);
        chk("drain", 64'(sb.size()), 0);
    endtask

    // rnd=0: stall window on out_ready_i at stream cycles 5..12.
    // rnd=1: random out_ready_i. Modes and data are random in both.
    task automatic stream(input int n, input bit rnd);
        int idx = 0;
        int t   = 0;
        logic [W-1:0] a, b, w;
        logic [1:0]   m;
        longint unsigned ea, eb;
        drv_lat = 1'b0;
        a = W'($urandom_range(0, 32'(QV - 1)));
        b = W'($urandom_range(0, 32'(QV - 1)));
        w = W'($urandom_range(0, 32'(QV - 1)));
        m = 2'($urandom_range(0, 3));
        while (idx < n && t < 1000) begin
            @(posedge clk_i); #1;
            out_ready_i = rnd ? ($urandom_range(0, 3) != 0) : !(t >= 5 && t <= 12);
            model(64'(a), 64'(b), 64'(w), m, ea, eb);
            a_i = a; b_i = b; twiddle_i = w; mode_i = m; tag_i = TW'(idx);
            drv_ea = W'(ea); drv_eb = W'(eb);
            in_valid_i = 1'b1;
            @(negedge clk_i);
            if (in_ready_o) begin
                idx++;
                a = W'($urandom_range(0, 32'(QV - 1)));
                b = W'($urandom_range(0, 32'(QV - 1)));
                w = W'($urandom_range(0, 32'(QV - 1)));
                m = 2'($urandom_range(0, 3));
            end
            t++;
        end
        if (idx < n) chk("stream_timeout", 64'(idx), 64'(n));
        drain(200);
        drv_lat = 1'b1;
    endtask

    initial begin
        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
        a_i = '0; b_i = '0; twiddle_i = '0; mode_i = '0; tag_i = '0;
        drv_ea = '0; drv_eb = '0; drv_lat = 1'b1;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_vld", 64'(out_valid_o), 0);
        chk("rst_a", 64'(a_out_o), 0);
        chk("rst_b", 64'(b_out_o), 0);
        chk("rst_tag", 64'(tag_o), 0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_rdy", 64'(in_ready_o), 1);

        // Directed values with hand-computed results.
        send(23'd1, 23'd2, 23'd3, 2'b00, 8'h5A, 7, 8380412);
        drain(20);
        repeat (3) begin
            @(negedge clk_i);
            chk("single_vld_once", 64'(out_valid_o), 0);
        end
        send(23'd5, 23'd8, 23'd2, 2'b01, 8'h11, 13, 8380411);
        send(23'd5, 23'd8, 23'd999, 2'b10, 8'h12, 13, 8380414);
        send(23'd8380416, 23'd8380416, 23'd8380416, 2'b00, 8'h13, 0, 8380415);
        send(23'd8380416, 23'd1, 23'd1, 2'b00, 8'h14, 0, 8380415);
        send(23'd0, 23'd0, 23'd0, 2'b11, 8'h15, 0, 0);
        drain(20);

        // Mixed modes back-to-back; latency 4 on each proves 1 beat/cycle.
        send_m(23'd123456, 23'd7654321, 23'd4000000, 2'b00, 8'h20);
        send_m(23'd8000000, 23'd8380000, 23'd1753, 2'b01, 8'h21);
        send_m(23'd42, 23'd8380400, 23'd77, 2'b10, 8'h22);
        send_m(23'd1, 23'd8380416, 23'd8380416, 2'b00, 8'h23);
        drain(20);

        stream(10, 1'b0);

        // Reset with three beats in flight: none may come out.
        send_m(23'd100, 23'd200, 23'd300, 2'b00, 8'h30);
        send_m(23'd400, 23'd500, 23'd600, 2'b01, 8'h31);
        send_m(23'd700, 23'd800, 23'd900, 2'b10, 8'h32);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        rst_i      = 1'b1;
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("midrst_vld", 64'(out_valid_o), 0);
        chk("midrst_rdy", 64'(in_ready_o), 1);
        repeat (8) begin
            @(negedge clk_i);
            chk("midrst_quiet", 64'(out_valid_o), 0);
        end
        send_m(23'd9, 23'd4, 23'd5, 2'b00, 8'h33);
        drain(20);

        stream(60, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
